// File: rtl/door_display_ctrl.sv
// -----------------------------------------------------------------------------
// door_display_ctrl
//
// Registered front-panel driver for the door lock. It turns the lock FSM state
// and the entered digit sequence into seven-segment bytes and RGB LED levels.
//
// Display content by state:
//   INIT  : hex dump of the entered sequence (nibble p at position p)
//   LSk   : k dashes, a blinking underscore cursor at position k, then blanks
//   OPEN  : "OPEn" on the rightmost four digits
//   ALARM : scrolling "CALL 911" banner, red LED flashing with the blink phase
//   other : all blank, LEDs off
//
// Ports:
//   clk    : system clock
//   nrst   : asynchronous active-low reset
//   state  : lock FSM state code (STATE_W bits)
//   seq    : entered digits, nibble i = i-th entered digit
//   ss     : segment bytes, ss[8d+7:8d] = digit d, digit NUM_DIGITS-1 leftmost
//            byte format {a,b,c,d,e,f,g,dp}
//   red    : red LED
//   green  : green LED
//   blue   : blue LED
//
// All outputs are registered with one cycle of latency from state/seq.
// -----------------------------------------------------------------------------
module door_display_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int BLINK_DIV  = 12_500_000,
  parameter int SCROLL_DIV = 25_000_000,
  parameter int STATE_W    = $clog2(NUM_DIGITS + 3)
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic [STATE_W-1:0]        state,
  input  logic [4*NUM_DIGITS-1:0]   seq,
  output logic [8*NUM_DIGITS-1:0]   ss,
  output logic                      red,
  output logic                      green,
  output logic                      blue
);

  localparam int RING_LEN = 8 + NUM_DIGITS;
  localparam int BLINK_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int SCROLL_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int IDX_W    = $clog2(RING_LEN);

  localparam logic [BLINK_W-1:0]  BLINK_MAX  = BLINK_W'(BLINK_DIV - 1);
  localparam logic [SCROLL_W-1:0] SCROLL_MAX = SCROLL_W'(SCROLL_DIV - 1);
  localparam logic [IDX_W-1:0]    IDX_MAX    = IDX_W'(RING_LEN - 1);
  localparam logic [IDX_W:0]      RING_LEN_X = (IDX_W + 1)'(RING_LEN);

  localparam logic [STATE_W-1:0] ST_OPEN  = STATE_W'(NUM_DIGITS);
  localparam logic [STATE_W-1:0] ST_ALARM = STATE_W'(NUM_DIGITS + 1);
  localparam logic [STATE_W-1:0] ST_INIT  = STATE_W'(NUM_DIGITS + 2);

  // Hex digit font, {a,b,c,d,e,f,g,dp}.
  function automatic logic [7:0] hex_font(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'hFC;
      4'h1: seg = 8'h60;
      4'h2: seg = 8'hDA;
      4'h3: seg = 8'hF2;
      4'h4: seg = 8'h66;
      4'h5: seg = 8'hB6;
      4'h6: seg = 8'hBE;
      4'h7: seg = 8'hE0;
      4'h8: seg = 8'hFE;
      4'h9: seg = 8'hF6;
      4'hA: seg = 8'hEE;
      4'hB: seg = 8'h3E;
      4'hC: seg = 8'h9C;
      4'hD: seg = 8'h7A;
      4'hE: seg = 8'h9E;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

  // Banner ring: "CALL 911" in slots 0..7, every later slot is blank.
  function automatic logic [7:0] ring_byte(input logic [IDX_W:0] idx);
    logic [7:0] seg;
    seg = 8'h00;
    if (idx < (IDX_W + 1)'(8)) begin
      case (idx[2:0])
        3'd0: seg = 8'h9C;
        3'd1: seg = 8'hEE;
        3'd2: seg = 8'h1C;
        3'd3: seg = 8'h1C;
        3'd4: seg = 8'h00;
        3'd5: seg = 8'hF6;
        default: seg = 8'h60;
      endcase
    end
    return seg;
  endfunction

  logic [BLINK_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                    phase_q, phase_d;
  logic [SCROLL_W-1:0]     scroll_cnt_q, scroll_cnt_d;
  logic [IDX_W-1:0]        scroll_idx_q, scroll_idx_d;
  logic [STATE_W-1:0]      prev_state_q, prev_state_d;
  logic [8*NUM_DIGITS-1:0] ss_q, ss_d;
  logic                    red_q, red_d;
  logic                    green_q, green_d;
  logic                    blue_q, blue_d;
  logic                    state_change;

  // Counter next-state. A state change restarts both timebases so a fresh
  // cursor always starts visible and the banner always starts at frame 0.
  always_comb begin
    state_change = (state != prev_state_q);
    prev_state_d = state;
    blink_cnt_d  = blink_cnt_q;
    phase_d      = phase_q;
    scroll_cnt_d = scroll_cnt_q;
    scroll_idx_d = scroll_idx_q;
    if (state_change) begin
      blink_cnt_d  = '0;
      phase_d      = 1'b1;
      scroll_cnt_d = '0;
      scroll_idx_d = '0;
    end else begin
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
      if (scroll_cnt_q == SCROLL_MAX) begin
        scroll_cnt_d = '0;
        scroll_idx_d = (scroll_idx_q == IDX_MAX) ? '0 : scroll_idx_q + 1'b1;
      end else begin
        scroll_cnt_d = scroll_cnt_q + 1'b1;
      end
    end
  end

  // Per-position decode. Decoding uses the *next* phase and scroll index so
  // the registered output already reflects a restart on the same edge.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_pos
      localparam logic [STATE_W-1:0] POS   = STATE_W'(gi);
      localparam logic [IDX_W:0]     POS_X = (IDX_W + 1)'(gi);
      localparam logic [7:0] OPEN_BYTE =
        (gi == NUM_DIGITS - 4) ? 8'hFC :
        (gi == NUM_DIGITS - 3) ? 8'hCE :
        (gi == NUM_DIGITS - 2) ? 8'h9E :
        (gi == NUM_DIGITS - 1) ? 8'h2A : 8'h00;

      logic [IDX_W:0] raw_idx;
      logic [IDX_W:0] ring_idx;
      logic [7:0]     seg;

      always_comb begin
        // scroll_idx < L and position < L, so one conditional subtract wraps.
        raw_idx  = {1'b0, scroll_idx_d} + POS_X;
        ring_idx = (raw_idx >= RING_LEN_X) ? (raw_idx - RING_LEN_X) : raw_idx;
        seg      = 8'h00;
        if (state == ST_INIT) begin
          seg = hex_font(seq[4*gi +: 4]);
        end else if (state < ST_OPEN) begin
          if (POS < state) begin
            seg = 8'h02;
          end else if (POS == state) begin
            seg = phase_d ? 8'h10 : 8'h00;
          end
        end else if (state == ST_OPEN) begin
          seg = OPEN_BYTE;
        end else if (state == ST_ALARM) begin
          seg = ring_byte(ring_idx);
        end
      end

      assign ss_d[8*(NUM_DIGITS-1-gi) +: 8] = seg;
    end
  endgenerate

  always_comb begin
    red_d   = (state == ST_ALARM) & phase_d;
    green_d = (state == ST_OPEN);
    blue_d  = (state < ST_OPEN);
  end

  // prev_state resets to all ones so the first edge after reset is treated
  // as a state change.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      scroll_cnt_q <= '0;
      scroll_idx_q <= '0;
      prev_state_q <= '1;
      ss_q         <= '0;
      red_q        <= 1'b0;
      green_q      <= 1'b0;
      blue_q       <= 1'b0;
    end else begin
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      scroll_cnt_q <= scroll_cnt_d;
      scroll_idx_q <= scroll_idx_d;
      prev_state_q <= prev_state_d;
      ss_q         <= ss_d;
      red_q        <= red_d;
      green_q      <= green_d;
      blue_q       <= blue_d;
    end
  end

  assign ss    = ss_q;
  assign red   = red_q;
  assign green = green_q;
  assign blue  = blue_q;

endmodule
